// File: rtl/adxl_seq_pkg.sv
// adxl_seq_pkg: shared constants and state types for the ADXL345 I2C sequencer.
//   I2C core register addresses, CR/SR bit positions, CR command bytes,
//   ADXL345 register addresses, and the sequencer / byte-op state enums.
package adxl_seq_pkg;
  localparam logic [2:0] REG_PRERLO = 3'd0;
  localparam logic [2:0] REG_PRERHI = 3'd1;
  localparam logic [2:0] REG_CTR    = 3'd2;
  localparam logic [2:0] REG_TXRRXR = 3'd3;
  localparam logic [2:0] REG_CRSR   = 3'd4;
  localparam int CR_STA   = 7;
  localparam int CR_STO   = 6;
  localparam int CR_RD    = 5;
  localparam int CR_WR    = 4;
  localparam int CR_ACK   = 3;
  localparam int SR_RXACK = 7;
  localparam int SR_TIP   = 1;
  localparam logic [7:0] CMD_STA_WR  = 8'((1 << CR_STA) | (1 << CR_WR));
  localparam logic [7:0] CMD_WR      = 8'(1 << CR_WR);
  localparam logic [7:0] CMD_WR_STO  = 8'((1 << CR_WR) | (1 << CR_STO));
  localparam logic [7:0] CMD_RD      = 8'(1 << CR_RD);
  localparam logic [7:0] CMD_RD_LAST = 8'((1 << CR_RD) | (1 << CR_ACK) | (1 << CR_STO));
  localparam logic [7:0] CMD_STO     = 8'(1 << CR_STO);
  localparam logic [7:0] CTR_EN      = 8'h80;
  localparam logic [7:0] ADXL_POWER_CTL   = 8'h2D;
  localparam logic [7:0] ADXL_DATA_FORMAT = 8'h31;
  localparam logic [7:0] ADXL_DATAX0      = 8'h32;
  localparam logic [7:0] PWR_MEASURE      = 8'h08;
  typedef enum logic [3:0] {
    IDLE, PRE_LO, PRE_HI, CORE_EN, CFG, WAIT_TICK,
    RD_ADDR, RD_REG, RD_RST, RD_BYTE, STOP, PUBLISH
  } seq_state_t;
  typedef enum logic [2:0] {B_IDLE, B_WR, B_CR, B_SR, B_RXR} op_state_t;
endpackage

// File: rtl/i2c_wb_byte_op.sv
// i2c_wb_byte_op: one Wishbone-driven operation on the opencores I2C core.
//   xfer=0: single register write (adr <= dat).
//   xfer=1: TXR <= dat, CR <= cr, poll SR until TIP clears; chk flags RxACK
//   as nack, rd additionally reads RXR into rx.
//   Ports: clk, rst_n, start (1-cycle request), xfer/chk/rd/adr/dat/cr (held
//   by caller while busy), wb_* master side, done (1-cycle), nack, rx.
module i2c_wb_byte_op
  import adxl_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       xfer,
  input  logic       chk,
  input  logic       rd,
  input  logic [2:0] adr,
  input  logic [7:0] dat,
  input  logic [7:0] cr,
  output logic [2:0] wb_adr,
  output logic [7:0] wb_wdat,
  input  logic [7:0] wb_rdat,
  output logic       wb_we,
  output logic       wb_stb,
  input  logic       wb_ack,
  output logic       done,
  output logic       nack,
  output logic [7:0] rx
);
  op_state_t state, nxt;
  logic gap, fin, ack;
  assign ack = wb_stb & wb_ack;
  // gap forces strobe low for one cycle after every acknowledged access
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= B_IDLE;
      gap <= 1'b0;
      done <= 1'b0;
      nack <= 1'b0;
      rx <= 8'h00;
    end else begin
      state <= nxt;
      gap <= ack;
      done <= fin;
      if (fin) nack <= state == B_SR && chk && wb_rdat[SR_RXACK];
      if (ack && state == B_RXR) rx <= wb_rdat;
    end
  always_comb begin
    nxt = state;
    fin = 1'b0;
    wb_stb = state != B_IDLE && !gap;
    wb_we = state == B_WR || state == B_CR;
    wb_adr = state == B_WR ? (xfer ? REG_TXRRXR : adr) : state == B_RXR ? REG_TXRRXR : REG_CRSR;
    wb_wdat = state == B_CR ? cr : dat;
    if (state == B_IDLE && start) nxt = B_WR;
    else if (ack)
      case (state)
        B_WR: begin
          nxt = xfer ? B_CR : B_IDLE;
          fin = !xfer;
        end
        B_CR: nxt = B_SR;
        B_SR: if (!wb_rdat[SR_TIP]) begin
          nxt = rd ? B_RXR : B_IDLE;
          fin = !rd;
        end
        B_RXR: begin
          nxt = B_IDLE;
          fin = 1'b1;
        end
        default: nxt = B_IDLE;
      endcase
  end
endmodule

// File: rtl/adxl_i2c_sequencer.sv
// adxl_i2c_sequencer: autonomous I2C master sequence for the ADXL345 via the opencores I2C core.
//   Initialises the core, configures the sensor, then reads X/Y/Z every sample tick.
//   Ports: clk_clk, reset_reset_n (async active-low), enable, wb_* (8-bit Wishbone
//   master to the I2C core, cyc==stb), accel_x/y/z (signed {DATAx1,DATAx0}),
//   sample_valid (1-cycle), nack_err (sticky until next good sample), busy.
//   Build option ADXL_AVG_EN: publish the arithmetic mean of every 4 reads.
module adxl_i2c_sequencer
  import adxl_seq_pkg::*;
#(
  parameter int         CLK_HZ      = 50_000_000,
  parameter int         I2C_HZ      = 400_000,
  parameter int         SAMPLE_HZ   = 100,
  parameter logic [6:0] DEV_ADDR    = 7'h53,
  parameter logic [7:0] DATA_FORMAT = 8'h0B
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  output logic [2:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        nack_err,
  output logic        busy
);
  localparam logic [15:0] PRESCALE = 16'(CLK_HZ / (5 * I2C_HZ) - 1);
  localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int TW = $clog2(TICK_DIV);
  seq_state_t state, nxt, rest;
  logic [2:0] idx, op_adr;
  logic [7:0] op_dat, op_cr, rx;
  logic [5:0][7:0] data_b;
  logic [TW-1:0] cnt;
  logic run, start, done, nack, op_xfer, op_chk, op_rd;
  logic init_done, pend, tick, tick_run, pub;
  logic [15:0] pub_x, pub_y, pub_z;
  i2c_wb_byte_op u_op (
    .clk(clk_clk), .rst_n(reset_reset_n), .start(start), .xfer(op_xfer), .chk(op_chk),
    .rd(op_rd), .adr(op_adr), .dat(op_dat), .cr(op_cr), .wb_adr(wb_adr_o), .wb_wdat(wb_dat_o),
    .wb_rdat(wb_dat_i), .wb_we(wb_we_o), .wb_stb(wb_stb_o), .wb_ack(wb_ack_i),
    .done(done), .nack(nack), .rx(rx)
  );
  assign wb_cyc_o = wb_stb_o;
  assign busy = !(state inside {IDLE, WAIT_TICK});
  assign start = !(state inside {IDLE, WAIT_TICK, PUBLISH}) && !run;
  // the counter also runs in WAIT_TICK before init_done so a failed CFG gets its retry tick
  assign tick_run = init_done || state == WAIT_TICK;
  assign tick = tick_run && cnt == TW'(TICK_DIV - 1);
  assign rest = enable ? WAIT_TICK : IDLE;
`ifdef ADXL_AVG_EN
  logic signed [17:0] sum_x, sum_y, sum_z, nx_x, nx_y, nx_z;
  logic [1:0] acnt;
  assign nx_x = sum_x + 18'($signed({data_b[1], data_b[0]}));
  assign nx_y = sum_y + 18'($signed({data_b[3], data_b[2]}));
  assign nx_z = sum_z + 18'($signed({data_b[5], data_b[4]}));
  assign pub = state == PUBLISH && acnt == 2'd3;
  assign pub_x = 16'(nx_x >>> 2);
  assign pub_y = 16'(nx_y >>> 2);
  assign pub_z = 16'(nx_z >>> 2);
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      sum_x <= '0;
      sum_y <= '0;
      sum_z <= '0;
      acnt <= 2'd0;
    end else if (state == PUBLISH || (done && nack)) begin
      sum_x <= state == PUBLISH && !pub ? nx_x : '0;
      sum_y <= state == PUBLISH && !pub ? nx_y : '0;
      sum_z <= state == PUBLISH && !pub ? nx_z : '0;
      acnt <= state == PUBLISH ? acnt + 2'd1 : 2'd0;
    end
`else
  assign pub = state == PUBLISH;
  assign pub_x = {data_b[1], data_b[0]};
  assign pub_y = {data_b[3], data_b[2]};
  assign pub_z = {data_b[5], data_b[4]};
`endif
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state <= IDLE;
      run <= 1'b0;
      idx <= 3'd0;
      init_done <= 1'b0;
      pend <= 1'b0;
      cnt <= '0;
      data_b <= '0;
      accel_x <= 16'h0000;
      accel_y <= 16'h0000;
      accel_z <= 16'h0000;
      sample_valid <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      state <= nxt;
      run <= start | (run & ~done);
      idx <= nxt != state ? 3'd0 : done ? idx + 3'd1 : idx;
      pend <= state inside {IDLE, WAIT_TICK} ? 1'b0 : pend | tick;
      cnt <= !tick_run ? cnt : tick ? '0 : cnt + 1'b1;
      if (state == RD_BYTE && done) data_b[idx] <= rx;
      if (state == CFG && done && !nack && idx == 3'd5) init_done <= 1'b1;
      sample_valid <= pub;
      if (done && nack) nack_err <= 1'b1;
      else if (pub) nack_err <= 1'b0;
      if (pub) begin
        accel_x <= pub_x;
        accel_y <= pub_y;
        accel_z <= pub_z;
      end
    end
  always_comb begin
    op_xfer = 1'b1;
    op_chk = 1'b1;
    op_rd = 1'b0;
    op_adr = REG_TXRRXR;
    op_dat = 8'h00;
    op_cr = CMD_WR;
    case (state)
      PRE_LO: begin
        op_xfer = 1'b0;
        op_adr = REG_PRERLO;
        op_dat = PRESCALE[7:0];
      end
      PRE_HI: begin
        op_xfer = 1'b0;
        op_adr = REG_PRERHI;
        op_dat = PRESCALE[15:8];
      end
      CORE_EN: begin
        op_xfer = 1'b0;
        op_adr = REG_CTR;
        op_dat = CTR_EN;
      end
      STOP: begin
        op_xfer = 1'b0;
        op_adr = REG_CRSR;
        op_dat = CMD_STO;
      end
      CFG: begin
        op_dat = idx == 3'd1 ? ADXL_POWER_CTL : idx == 3'd2 ? PWR_MEASURE :
                 idx == 3'd4 ? ADXL_DATA_FORMAT : idx == 3'd5 ? DATA_FORMAT : {DEV_ADDR, 1'b0};
        op_cr = idx == 3'd0 || idx == 3'd3 ? CMD_STA_WR : idx == 3'd2 || idx == 3'd5 ? CMD_WR_STO : CMD_WR;
      end
      RD_ADDR: begin
        op_dat = {DEV_ADDR, 1'b0};
        op_cr = CMD_STA_WR;
      end
      RD_REG: op_dat = ADXL_DATAX0;
      RD_RST: begin
        op_dat = {DEV_ADDR, 1'b1};
        op_cr = CMD_STA_WR;
      end
      RD_BYTE: begin
        op_chk = 1'b0;
        op_rd = 1'b1;
        op_cr = idx == 3'd5 ? CMD_RD_LAST : CMD_RD;
      end
      default: ;
    endcase
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (enable) nxt = init_done ? CFG : PRE_LO;
      PRE_LO: if (done) nxt = PRE_HI;
      PRE_HI: if (done) nxt = CORE_EN;
      CORE_EN: if (done) nxt = CFG;
      CFG: if (done) nxt = nack ? STOP : idx == 3'd5 ? rest : CFG;
      WAIT_TICK: nxt = !enable ? IDLE : (tick || pend) ? (init_done ? RD_ADDR : CFG) : WAIT_TICK;
      RD_ADDR: if (done) nxt = nack ? STOP : RD_REG;
      RD_REG: if (done) nxt = nack ? STOP : RD_RST;
      RD_RST: if (done) nxt = nack ? STOP : RD_BYTE;
      RD_BYTE: if (done && idx == 3'd5) nxt = PUBLISH;
      STOP: if (done) nxt = rest;
      PUBLISH: nxt = rest;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_adxl_i2c_sequencer.sv
// tb_adxl_i2c_sequencer: directed bench with an opencores I2C core model and ADXL345 slave model.
module tb_adxl_i2c_sequencer;
`ifdef ADXL_AVG_EN
  localparam int SV_LIM = 12000;
`else
  localparam int SV_LIM = 5000;
`endif
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [2:0] wb_adr;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic wb_we, wb_stb, wb_cyc, wb_ack;
  logic [15:0] ax, ay, az;
  logic sv, nack_err, busy;
  int checks = 0, fails = 0;
  logic [7:0] txr = 8'h00, rxr = 8'h00, ptr = 8'h00;
  logic [3:0] tip;
  logic rxack, first = 1'b0, hold = 1'b0, seq_en = 1'b0;
  int nack_req = 0, nack_used = 0, sto_cnt = 0, rd_cnt = 0, seq_i = 0, seq_base = 0, wbase = 0;
  logic [7:0] sdata [6];
  logic [15:0] xseq [4];
  logic [15:0] xv;
  logic [10:0] wlog [$];
  logic [10:0] init_seq [15] = '{11'h018, 11'h100, 11'h280, 11'h3A6, 11'h490, 11'h32D, 11'h410,
    11'h308, 11'h450, 11'h3A6, 11'h490, 11'h331, 11'h410, 11'h30B, 11'h450};
  always #5 clk = ~clk;
  adxl_i2c_sequencer #(.SAMPLE_HZ(25000)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_we_o(wb_we), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_ack_i(wb_ack),
    .accel_x(ax), .accel_y(ay), .accel_z(az), .sample_valid(sv), .nack_err(nack_err), .busy(busy)
  );
  assign xv = xseq[2'(seq_i - seq_base - 1)];
  assign wb_dat_i = wb_adr == 3'd4 ? {rxack, 5'b0, tip != 4'd0, 1'b0} : rxr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_ack <= 1'b0;
      tip <= 4'd0;
      rxack <= 1'b0;
    end else begin
      wb_ack <= wb_stb & ~wb_ack & ~hold;
      if (tip != 4'd0) tip <= tip - 4'd1;
      if (wb_stb && wb_ack && wb_we) begin
        wlog.push_back({wb_adr, wb_dat_o});
        if (wb_adr == 3'd3) txr <= wb_dat_o;
        if (wb_adr == 3'd4) begin
          tip <= 4'd6;
          if (wb_dat_o == 8'h40) sto_cnt <= sto_cnt + 1;
          if (wb_dat_o[7] && wb_dat_o[4]) begin
            rxack <= nack_req != nack_used || txr[7:1] != 7'h53;
            nack_used <= nack_req;
            first <= 1'b1;
            if (txr[0]) begin
              rd_cnt <= 0;
              seq_i <= seq_i + 1;
            end
          end else if (wb_dat_o[4]) begin
            rxack <= 1'b0;
            first <= 1'b0;
            ptr <= first ? txr : ptr + 8'd1;
          end else if (wb_dat_o[5]) begin
            rxr <= seq_en && ptr == 8'h32 ? xv[7:0] : seq_en && ptr == 8'h33 ? xv[15:8] : sdata[3'(ptr - 8'h32)];
            ptr <= ptr + 8'd1;
            rd_cnt <= rd_cnt + 1;
          end
        end
      end
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wait_sv(input string tag);
    int n = 0;
    while (!sv && n < SV_LIM) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sv"}, 32'(sv), 1);
  endtask
  task automatic check_init(input string tag);
    int n = 0;
    while (wlog.size() < wbase + 15 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_count"}, 32'(wlog.size() >= wbase + 15), 1);
    if (wlog.size() >= wbase + 15)
      for (int i = 0; i < 15; i++) check($sformatf("%s_w%0d", tag, i), 32'(wlog[wbase + i]), 32'(init_seq[i]));
  endtask
  task automatic load(input logic [7:0] b0, b1, b2, b3, b4, b5);
    sdata[0] = b0; sdata[1] = b1; sdata[2] = b2; sdata[3] = b3; sdata[4] = b4; sdata[5] = b5;
  endtask
  initial begin
    int n, bad;
    logic [2:0] a0;
    logic [7:0] d0;
    logic w0;
    load(8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h80);
    xseq[0] = 16'h0004; xseq[1] = 16'h0008; xseq[2] = 16'hFFFC; xseq[3] = 16'hFFF8;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_stb", 32'(wb_stb), 0);
    check("rst_sv", 32'(sv), 0);
    check("rst_x", 32'(ax), 0);
    check("rst_nack", 32'(nack_err), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    check_init("init1");
    wait_sv("t2");
    check("t2_x", 32'(ax), 32'h1234);
    check("t2_y", 32'(ay), 32'hABCD);
    check("t2_z", 32'(az), 32'h8000);
    check("t2_nack", 32'(nack_err), 0);
    check("t2_cyc", 32'(wb_cyc), 32'(wb_stb));
    @(negedge clk);
    check("t2_pulse", 32'(sv), 0);
    load(8'h01, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h00);
    n = sto_cnt;
    nack_req++;
    bad = 0;
    while (sto_cnt == n && bad < SV_LIM) begin
      @(negedge clk);
      bad++;
    end
    check("t3_sto", 32'(sto_cnt != n), 1);
    repeat (3) @(negedge clk);
    check("t3_nack_set", 32'(nack_err), 1);
    repeat (10) @(negedge clk);
    check("t3_idle", 32'(busy), 0);
    wait_sv("t3");
    check("t3_nack_clr", 32'(nack_err), 0);
    check("t3_x", 32'(ax), 32'h0001);
    check("t3_y", 32'(ay), 32'hFFFF);
    check("t3_z", 32'(az), 32'h007F);
    load(8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00);
    @(negedge clk);
    n = 0;
    while (!(busy && wb_stb && !wb_ack) && n < SV_LIM) begin
      @(negedge clk);
      n++;
    end
    hold = 1'b1;
    a0 = wb_adr; d0 = wb_dat_o; w0 = wb_we;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (wb_stb !== 1'b1 || wb_adr != a0 || wb_dat_o != d0 || wb_we != w0 || wb_ack) bad++;
    end
    check("t4_hold", 32'(bad), 0);
    hold = 1'b0;
    wait_sv("t4");
    check("t4_x", 32'(ax), 32'h0010);
    check("t4_y", 32'(ay), 32'h0020);
    check("t4_z", 32'(az), 32'h0030);
    n = 0;
    while (!(busy && rd_cnt == 4) && n < SV_LIM) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached", 32'(rd_cnt), 4);
    rst_n = 1'b0;
    #1;
    check("t5_x", 32'(ax), 0);
    check("t5_y", 32'(ay), 0);
    check("t5_z", 32'(az), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_stb", 32'(wb_stb), 0);
    check("t5_sv", 32'(sv), 0);
    wbase = wlog.size();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_init("init2");
    wait_sv("t5");
    check("t5_rec_x", 32'(ax), 32'h0010);
`ifdef ADXL_AVG_EN
    @(negedge clk);
    seq_base = seq_i;
    seq_en = 1'b1;
    wait_sv("t6");
    check("t6_x", 32'(ax), 0);
    check("t6_reads", 32'(seq_i - seq_base), 4);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
